// File: rtl/frame_draw_scheduler_pkg.sv
// Shared definitions for the frame draw scheduler.
//   state_e     : scheduler phases (IDLE, LATCH, ERASE, DRAW, DONE)
//   BLACK       : erase colour
//   DEF_*       : default character count, sprite size and play-field origin
//   next_set()  : lowest set bit of an 8-bit mask at or above a start index,
//                 returned as {none_found, index}
package frame_draw_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ERASE,
    DRAW,
    DONE
  } state_e;

  localparam logic [2:0]  BLACK       = 3'b000;
  localparam int unsigned DEF_N_CHARS = 5;
  localparam int unsigned DEF_SPR_W   = 5;
  localparam int unsigned DEF_SPR_H   = 5;
  localparam int unsigned DEF_X_OFF   = 26;
  localparam int unsigned DEF_Y_OFF   = 1;

  function automatic logic [3:0] next_set(input logic [7:0] mask, input logic [3:0] from);
    logic       found;
    logic [2:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && mask[i] && (4'(i) >= from)) begin
        found = 1'b1;
        idx   = 3'(i);
      end
    end
    return {~found, idx};
  endfunction

endpackage

// File: rtl/frame_draw_scheduler_box_scan_counter.sv
// Nested character / row / column scan over SPR_W x SPR_H boxes.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : restart at the first character selected by mask_i, pixel (0,0)
//   en_i          : advance one pixel; after the last pixel of a box, jump to the
//                   next selected character
//   mask_i        : characters to visit (all ones visits every character)
//   c_o, px_o, py_o : current character and pixel offsets
//   last_o        : current pixel is the final one of the scan
//   none_o        : mask selects no character at all
module box_scan_counter
  import frame_draw_scheduler_pkg::*;
#(
  parameter int unsigned N_CHARS = DEF_N_CHARS,
  parameter int unsigned SPR_W   = DEF_SPR_W,
  parameter int unsigned SPR_H   = DEF_SPR_H
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic [N_CHARS-1:0] mask_i,
  output logic [2:0]         c_o,
  output logic [7:0]         px_o,
  output logic [7:0]         py_o,
  output logic               last_o,
  output logic               none_o
);

  logic [2:0] c_q, c_d;
  logic [7:0] px_q, px_d, py_q, py_d;
  logic [7:0] mask_w;
  logic [3:0] first_w, next_w;
  logic       box_end;

  assign mask_w  = 8'(mask_i);
  assign first_w = next_set(mask_w, 4'd0);
  assign next_w  = next_set(mask_w, {1'b0, c_q} + 4'd1);
  assign box_end = (px_q == 8'(SPR_W - 1)) && (py_q == 8'(SPR_H - 1));
  assign last_o  = box_end & next_w[3];
  assign none_o  = first_w[3];

  always_comb begin
    c_d  = c_q;
    px_d = px_q;
    py_d = py_q;
    if (clear_i) begin
      c_d  = first_w[2:0];
      px_d = '0;
      py_d = '0;
    end else if (en_i) begin
      if (px_q == 8'(SPR_W - 1)) begin
        px_d = '0;
        if (py_q == 8'(SPR_H - 1)) begin
          py_d = '0;
          c_d  = next_w[2:0];
        end else begin
          py_d = py_q + 8'd1;
        end
      end else begin
        px_d = px_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_q  <= '0;
      px_q <= '0;
      py_q <= '0;
    end else begin
      c_q  <= c_d;
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  assign c_o  = c_q;
  assign px_o = px_q;
  assign py_o = py_q;

endmodule

// File: rtl/frame_draw_scheduler.sv
// Per-frame owner of the single VGA write port.
// On frame_tick: latch new positions, erase every old 5x5 box to black, run the
// sprite drawer for a fixed cycle count, then return the port to the maze renderer.
//   clock_50, reset_n          : clock, async active-low reset
//   frame_tick                 : frame start pulse
//   pos_x, pos_y               : packed per-character positions
//   spr_run/spr_char/spr_x/spr_y and spr_v*/spr_color/spr_plot : sprite drawer link
//   mz_req/mz_x/mz_y/mz_color/mz_gnt : maze renderer link (granted only in IDLE)
//   vga_x/vga_y/vga_color/vga_plot   : registered adapter write port
//   busy, frame_done, overrun        : status
// Build option SKIP_STATIC_ERASE_EN: characters that did not move are not erased.
module frame_draw_scheduler
  import frame_draw_scheduler_pkg::*;
#(
  parameter int unsigned N_CHARS = DEF_N_CHARS,
  parameter int unsigned SPR_W   = DEF_SPR_W,
  parameter int unsigned SPR_H   = DEF_SPR_H,
  parameter int unsigned X_OFF   = DEF_X_OFF,
  parameter int unsigned Y_OFF   = DEF_Y_OFF
) (
  input  logic                 clock_50,
  input  logic                 reset_n,
  input  logic                 frame_tick,
  input  logic [8*N_CHARS-1:0] pos_x,
  input  logic [8*N_CHARS-1:0] pos_y,
  output logic                 spr_run,
  input  logic [2:0]           spr_char,
  output logic [7:0]           spr_x,
  output logic [7:0]           spr_y,
  input  logic [7:0]           spr_vx,
  input  logic [7:0]           spr_vy,
  input  logic [2:0]           spr_color,
  input  logic                 spr_plot,
  input  logic                 mz_req,
  input  logic [7:0]           mz_x,
  input  logic [7:0]           mz_y,
  input  logic [2:0]           mz_color,
  output logic                 mz_gnt,
  output logic [7:0]           vga_x,
  output logic [7:0]           vga_y,
  output logic [2:0]           vga_color,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int unsigned BOX_CYCLES = N_CHARS * SPR_W * SPR_H;

  state_e     state_q, state_d;
  logic [7:0] cur_x_q  [N_CHARS];
  logic [7:0] cur_y_q  [N_CHARS];
  logic [7:0] prev_x_q [N_CHARS];
  logic [7:0] prev_y_q [N_CHARS];
  logic [7:0] draw_cnt_q, draw_cnt_d;
  logic       overrun_q;
  logic [7:0] vga_x_q, vga_y_q, src_x, src_y;
  logic [2:0] vga_color_q, src_color;
  logic       vga_plot_q, src_plot;

  logic [N_CHARS-1:0] erase_mask;
  logic [2:0]         sc_c, spr_sel;
  logic [7:0]         sc_px, sc_py;
  logic               sc_last, sc_none;

`ifdef SKIP_STATIC_ERASE_EN
  // During LATCH cur is not yet loaded, so compare the incoming positions;
  // this lets an all-static frame go straight from LATCH to DRAW.
  always_comb begin
    erase_mask = '0;
    for (int unsigned i = 0; i < N_CHARS; i++) begin
      if (state_q == LATCH) begin
        erase_mask[i] = (pos_x[8*i +: 8] != prev_x_q[i]) || (pos_y[8*i +: 8] != prev_y_q[i]);
      end else begin
        erase_mask[i] = (cur_x_q[i] != prev_x_q[i]) || (cur_y_q[i] != prev_y_q[i]);
      end
    end
  end
`else
  assign erase_mask = '1;
`endif

  box_scan_counter #(
    .N_CHARS(N_CHARS),
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H)
  ) u_scan (
    .clk_i  (clock_50),
    .rst_ni (reset_n),
    .clear_i(state_q == LATCH),
    .en_i   (state_q == ERASE),
    .mask_i (erase_mask),
    .c_o    (sc_c),
    .px_o   (sc_px),
    .py_o   (sc_py),
    .last_o (sc_last),
    .none_o (sc_none)
  );

  always_comb begin
    state_d    = state_q;
    draw_cnt_d = draw_cnt_q;
    mz_gnt     = 1'b0;
    spr_run    = 1'b0;
    src_plot   = 1'b0;
    src_x      = '0;
    src_y      = '0;
    src_color  = BLACK;
    case (state_q)
      IDLE: begin
        mz_gnt    = mz_req & ~frame_tick;
        src_plot  = mz_req & ~frame_tick;
        src_x     = mz_x;
        src_y     = mz_y;
        src_color = mz_color;
        if (frame_tick) state_d = LATCH;
      end
      LATCH: begin
        draw_cnt_d = '0;
        state_d    = sc_none ? DRAW : ERASE;
      end
      ERASE: begin
        src_plot = 1'b1;
        src_x    = prev_x_q[sc_c] + sc_px + 8'(X_OFF);
        src_y    = prev_y_q[sc_c] + sc_py + 8'(Y_OFF);
        if (sc_last) state_d = DRAW;
      end
      DRAW: begin
        spr_run    = 1'b1;
        src_plot   = spr_plot;
        src_x      = spr_vx;
        src_y      = spr_vy;
        src_color  = spr_color;
        draw_cnt_d = draw_cnt_q + 8'd1;
        if (draw_cnt_q == 8'(BOX_CYCLES - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      draw_cnt_q  <= '0;
      overrun_q   <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_plot_q  <= 1'b0;
      for (int unsigned i = 0; i < N_CHARS; i++) begin
        cur_x_q[i]  <= '0;
        cur_y_q[i]  <= '0;
        prev_x_q[i] <= '0;
        prev_y_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      draw_cnt_q  <= draw_cnt_d;
      vga_x_q     <= src_x;
      vga_y_q     <= src_y;
      vga_color_q <= src_color;
      vga_plot_q  <= src_plot;
      if ((state_q != IDLE) && frame_tick) overrun_q <= 1'b1;
      for (int unsigned i = 0; i < N_CHARS; i++) begin
        if (state_q == LATCH) begin
          cur_x_q[i] <= pos_x[8*i +: 8];
          cur_y_q[i] <= pos_y[8*i +: 8];
        end
        if (state_q == DONE) begin
          prev_x_q[i] <= cur_x_q[i];
          prev_y_q[i] <= cur_y_q[i];
        end
      end
    end
  end

  // Drawer indices beyond the character count fall back to character 0.
  assign spr_sel    = (32'(spr_char) < N_CHARS) ? spr_char : 3'd0;
  assign spr_x      = cur_x_q[spr_sel];
  assign spr_y      = cur_y_q[spr_sel];
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_color  = vga_color_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign overrun    = overrun_q;

endmodule

// File: doc/frame_draw_scheduler.md
Name: frame_draw_scheduler

Overview:
Owns the single VGA write port once per game frame. On each frame tick it sequences three phases: erase every character's previous 5x5 box to black, run the sprite drawer over all characters at their newly latched positions, then hand the port back to the maze/pellet renderer. It sits between the game-logic position registers, the sprite drawer, the maze renderer and the VGA adapter.

Parameters:
N_CHARS, 5, number of characters (pacman plus 4 ghosts), indexed 0..N_CHARS-1
SPR_W, 5, sprite width in pixels
SPR_H, 5, sprite height in pixels
X_OFF, 26, screen x origin of the play field
Y_OFF, 1, screen y origin of the play field

Ports:
clock_50  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse that starts a frame
pos_x  in  8*N_CHARS  packed character x positions, char i at [8i+7:8i]
pos_y  in  8*N_CHARS  packed character y positions
spr_run  out  1  drawer enable; drawer is held at character 0, pixel (0,0) while low
spr_char  in  3  character index currently being drawn by the drawer
spr_x  out  8  latched x position of character spr_char
spr_y  out  8  latched y position of character spr_char
spr_vx  in  8  drawer pixel x (includes X_OFF)
spr_vy  in  8  drawer pixel y
spr_color  in  3  drawer colour
spr_plot  in  1  drawer plot strobe
mz_req  in  1  maze renderer pixel request
mz_x  in  8  maze pixel x
mz_y  in  8  maze pixel y
mz_color  in  3  maze pixel colour
mz_gnt  out  1  maze pixel accepted this cycle
vga_x  out  8  adapter x
vga_y  out  8  adapter y
vga_color  out  3  adapter colour
vga_plot  out  1  adapter write strobe
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at end of frame
overrun  out  1  sticky; set when frame_tick arrives while busy

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0. cur/prev position registers 0. Counters 0. Reset mid-frame aborts the frame immediately and leaves no pending plot.
- vga_* are registered and lag their source by exactly 1 cycle. vga_plot=0 whenever the source does not plot.
- IDLE: mz_gnt = mz_req & ~frame_tick. A granted pixel appears on vga_* the next cycle. frame_tick moves to LATCH and takes priority over mz_req in the same cycle.
- LATCH (1 cycle): cur_x/cur_y <= pos_x/pos_y. Clear char/px/py counters. Next state is ERASE.
- ERASE: per cycle, plot colour 3'b000 at (prev_x[c]+px+X_OFF, prev_y[c]+py+Y_OFF), with 8-bit wrap-around sums. px runs 0..SPR_W-1, then py increments, then c increments. After c=N_CHARS-1, px=SPR_W-1, py=SPR_H-1 the next state is DRAW. Duration N_CHARS*SPR_W*SPR_H cycles (125 with defaults).
- DRAW: spr_run=1. spr_x/spr_y = cur[spr_char]; spr_char values >= N_CHARS select 0. vga_* follow spr_vx/spr_vy/spr_color/spr_plot. A cycle counter ends the phase after N_CHARS*SPR_W*SPR_H cycles. Next state is DONE and spr_run drops.
- DONE (1 cycle): prev <= cur. frame_done=1. Next state is IDLE.
- frame_tick while busy: ignored, overrun <= 1. Only reset clears overrun.
- mz_gnt=0 in all non-IDLE states. The maze renderer must hold its request until granted.

Optional Feature:
SKIP_STATIC_ERASE_EN. When defined, a character whose cur position equals its prev position is not erased: its 25 cycles are skipped entirely (c advances directly), so ERASE is shorter. If all characters are static, ERASE lasts 0 cycles and LATCH goes straight to DRAW. When undefined, all characters are always erased, with the fixed 125-cycle phase.

Decomposition:
- Shared package: state enum (IDLE, LATCH, ERASE, DRAW, DONE), colour constants (BLACK=3'b000), default play-field origin, sprite dimensions.
- One sub-module, box_scan_counter: nested c/py/px counter with clear, enable and last flag. Used by ERASE. The DRAW cycle count uses a plain counter.

Test Plan:
- Reset mid-DRAW (reset_n=0 at cycle 40 of DRAW) -> vga_plot=0 and busy=0 the same cycle. Next frame erases at origin (prev=0).
- First frame, pos char0=(10,20) -> first erase plot at (26,1) colour 0. DRAW begins 127 cycles after the tick. spr_x=10, spr_y=20 while spr_char=0. frame_done 252 cycles after the tick.
- Second frame, char0 moved to (11,20) -> erase box covers x 36..40, y 21..25, colour 0.
- mz_req held with frame_tick in the same IDLE cycle -> mz_gnt=0. Maze pixel granted on the first IDLE cycle after frame_done and visible on vga_* one cycle later.
- frame_tick pulsed during ERASE -> overrun=1, frame length unchanged, overrun still 1 after next frame.
- With SKIP_STATIC_ERASE_EN defined and all positions unchanged -> no black plots; LATCH is followed directly by DRAW; frame_done 127 cycles after the tick.
